adc_trig_capture: RTL

- Sits directly downstream of the ADC344x LVDS receiver (ADC344x_Top), in the SysSampleClk (100 MHz) domain.
- Consumes AdcDataValid plus four 14-bit channel words.
- Performs a level/slope trigger on a selectable channel and stores a pre/post-trigger window of all channels in an internal circular RAM.
- Exposes a synchronous read port for the PS/AXI side to unload the window.

---
 rtl/adc_trig_capture.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_trig_capture.sv
// adc_trig_capture: level/slope triggered capture of a pre/post-trigger window of
// four ADC channels into a circular block RAM. The window is unloaded through a
// registered read port addressed relative to the oldest sample in the window.
// Optional build macro ADC_CAP_FORCE_TRIG_EN adds the ForceTrig input.
module adc_trig_capture #(
    parameter int C_AdcBits   = 14,
    parameter int C_AdcChnls  = 4,
    parameter int C_DepthLog2 = 10
) (
    input  logic                              SysSampleClk,
    input  logic                              SysSampleRst,
    input  logic                              AdcDataValid,
    input  logic [C_AdcBits-1:0]              AdcDataCh0,
    input  logic [C_AdcBits-1:0]              AdcDataCh1,
    input  logic [C_AdcBits-1:0]              AdcDataCh2,
    input  logic [C_AdcBits-1:0]              AdcDataCh3,
    input  logic                              Arm,
    input  logic [1:0]                        TrigChSel,
    input  logic [C_AdcBits-1:0]              TrigLevel,
    input  logic                              TrigSlope,
    input  logic [C_DepthLog2-1:0]            PreTrigLen,
`ifdef ADC_CAP_FORCE_TRIG_EN
    input  logic                              ForceTrig,
`endif
    output logic                              Busy,
    output logic                              Done,
    output logic [C_DepthLog2-1:0]            TrigAddr,
    input  logic                              RdEn,
    input  logic [C_DepthLog2-1:0]            RdAddr,
    output logic [C_AdcChnls*C_AdcBits-1:0]   RdData,
    output logic                              RdValid
);

    localparam int C_Depth    = 1 << C_DepthLog2;
    localparam int C_WordBits = C_AdcChnls * C_AdcBits;
    localparam logic [C_DepthLog2-1:0] C_MaxIdx = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT_TRIG,
        ST_POST,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [C_DepthLog2-1:0] wptr_q, wptr_d;
    logic [C_DepthLog2-1:0] cnt_q, cnt_d;
    logic [C_DepthLog2-1:0] start_ptr_q, start_ptr_d;
    logic [C_DepthLog2-1:0] trig_addr_q, trig_addr_d;
    logic [C_DepthLog2-1:0] pre_q, pre_d;
    logic [1:0]             trig_ch_q, trig_ch_d;
    logic [C_AdcBits-1:0]   level_q, level_d;
    logic                   slope_q, slope_d;
    logic [C_AdcBits-1:0]   prev_q, prev_d;
    logic                   prev_valid_q, prev_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
`ifdef ADC_CAP_FORCE_TRIG_EN
    logic                   force_pend_q, force_pend_d;
`endif

    logic [C_AdcBits-1:0]   cur_sample;
    logic                   trig_fire;
    logic                   wr_en;
    logic [C_WordBits-1:0]  wr_word;
    logic [C_DepthLog2-1:0] rd_phys;
    logic [C_WordBits-1:0]  rd_data_q;
    logic                   rd_valid_q;

    logic [C_WordBits-1:0]  mem [C_Depth];

    assign wr_word = {AdcDataCh3, AdcDataCh2, AdcDataCh1, AdcDataCh0};
    assign rd_phys = start_ptr_q + RdAddr;

    // Select the trigger source channel and evaluate the crossing against the previous sample
    always_comb begin
        cur_sample = AdcDataCh0;
        case (trig_ch_q)
            2'd1:    cur_sample = AdcDataCh1;
            2'd2:    cur_sample = AdcDataCh2;
            2'd3:    cur_sample = AdcDataCh3;
            default: cur_sample = AdcDataCh0;
        endcase
        if (slope_q)
            trig_fire = prev_valid_q && (prev_q > level_q) && (cur_sample <= level_q);
        else
            trig_fire = prev_valid_q && (prev_q < level_q) && (cur_sample >= level_q);
`ifdef ADC_CAP_FORCE_TRIG_EN
        trig_fire = trig_fire || force_pend_q || ForceTrig;
`endif
        wr_en = AdcDataValid && !SysSampleRst &&
                ((state_q == ST_PRE) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST));
    end

    // Capture sequencer next-state logic; everything holds while AdcDataValid is low
    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        cnt_d        = cnt_q;
        start_ptr_d  = start_ptr_q;
        trig_addr_d  = trig_addr_q;
        pre_d        = pre_q;
        trig_ch_d    = trig_ch_q;
        level_d      = level_q;
        slope_d      = slope_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        busy_d       = busy_q;
        done_d       = done_q;
`ifdef ADC_CAP_FORCE_TRIG_EN
        force_pend_d = force_pend_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Arm) begin
                    // PreTrigLen is port-width limited to N-1, so no further clamp is needed
                    pre_d        = PreTrigLen;
                    trig_ch_d    = TrigChSel;
                    level_d      = TrigLevel;
                    slope_d      = TrigSlope;
                    cnt_d        = PreTrigLen;
                    prev_valid_d = 1'b0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
`ifdef ADC_CAP_FORCE_TRIG_EN
                    force_pend_d = 1'b0;
`endif
                    state_d      = (PreTrigLen != '0) ? ST_PRE : ST_WAIT_TRIG;
                end
            end
            ST_PRE: begin
                if (AdcDataValid) begin
                    wptr_d       = wptr_q + 1'b1;
                    prev_d       = cur_sample;
                    prev_valid_d = 1'b1;
                    cnt_d        = cnt_q - 1'b1;
                    if (cnt_q == 1) state_d = ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
`ifdef ADC_CAP_FORCE_TRIG_EN
                if (ForceTrig) force_pend_d = 1'b1;
`endif
                if (AdcDataValid) begin
                    wptr_d       = wptr_q + 1'b1;
                    prev_d       = cur_sample;
                    prev_valid_d = 1'b1;
                    if (trig_fire) begin
                        trig_addr_d = pre_q;
                        start_ptr_d = wptr_q - pre_q;
                        cnt_d       = C_MaxIdx - pre_q;
`ifdef ADC_CAP_FORCE_TRIG_EN
                        force_pend_d = 1'b0;
`endif
                        if (pre_q == C_MaxIdx) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_POST;
                        end
                    end
                end
            end
            ST_POST: begin
                if (AdcDataValid) begin
                    wptr_d = wptr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == 1) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // Register sequencer state, pointers and latched trigger configuration
    always_ff @(posedge SysSampleClk) begin
        if (SysSampleRst) begin
            state_q      <= ST_IDLE;
            wptr_q       <= '0;
            cnt_q        <= '0;
            start_ptr_q  <= '0;
            trig_addr_q  <= '0;
            pre_q        <= '0;
            trig_ch_q    <= '0;
            level_q      <= '0;
            slope_q      <= 1'b0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef ADC_CAP_FORCE_TRIG_EN
            force_pend_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            cnt_q        <= cnt_d;
            start_ptr_q  <= start_ptr_d;
            trig_addr_q  <= trig_addr_d;
            pre_q        <= pre_d;
            trig_ch_q    <= trig_ch_d;
            level_q      <= level_d;
            slope_q      <= slope_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef ADC_CAP_FORCE_TRIG_EN
            force_pend_q <= force_pend_d;
`endif
        end
    end

    // Capture RAM write port, kept free of reset so it maps onto block RAM
    always_ff @(posedge SysSampleClk) begin
        if (wr_en) mem[wptr_q] <= wr_word;
    end

    // Registered read port relative to the window start
    always_ff @(posedge SysSampleClk) begin
        if (SysSampleRst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= RdEn;
            if (RdEn) rd_data_q <= mem[rd_phys];
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign TrigAddr = trig_addr_q;
    assign RdData   = rd_data_q;
    assign RdValid  = rd_valid_q;

endmodule
